// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: evaluates issued branches/jumps and queues
// the resolved results in an in-order FIFO toward the completion path.

module conditional_branch #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      func,
  output logic            taken
);

  // funct3 condition decode; reserved codes never take
  always_comb begin
    taken = 1'b0;
    unique case (func)
      3'b000:  taken = (rs1 == rs2);
      3'b001:  taken = (rs1 != rs2);
      3'b100:  taken = ($signed(rs1) < $signed(rs2));
      3'b101:  taken = ($signed(rs1) >= $signed(rs2));
      3'b110:  taken = (rs1 < rs2);
      3'b111:  taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 5,
  parameter int DEPTH     = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [XLEN-1:0]      issue_rs1,
  input  logic [XLEN-1:0]      issue_rs2,
  input  logic [2:0]           issue_func,
  input  logic                 issue_is_jal,
  input  logic                 issue_is_jalr,
  input  logic [XLEN-1:0]      issue_pc,
  input  logic [XLEN-1:0]      issue_imm,
  input  logic                 issue_pred_taken,
  input  logic [XLEN-1:0]      issue_pred_target,
  input  logic [ROB_IDX_W-1:0] issue_rob_idx,
  input  logic                 squash,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ROB_IDX_W-1:0] out_rob_idx,
  output logic                 out_taken,
  output logic [XLEN-1:0]      out_next_pc,
  output logic [XLEN-1:0]      out_link,
  output logic                 out_mispredict
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic                 taken;
    logic [XLEN-1:0]      next_pc;
    logic [XLEN-1:0]      link;
    logic                 mispredict;
  } entry_t;

  entry_t mem_q [DEPTH];

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;

  logic            cond;
  logic            taken;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;
  logic [XLEN-1:0] next_pc;
  logic            mispredict;
  logic            push;
  logic            pop;
  entry_t          new_e;
  entry_t          head_e;

  conditional_branch #(
    .XLEN(XLEN)
  ) u_cond (
    .rs1  (issue_rs1),
    .rs2  (issue_rs2),
    .func (issue_func),
    .taken(cond)
  );

  // resolve direction, target and prediction check for the issue
  always_comb begin
    jalr_sum = issue_rs1 + issue_imm;
    taken    = issue_is_jal | issue_is_jalr | cond;
    if (issue_is_jalr) begin
      target = {jalr_sum[XLEN-1:1], 1'b0};
    end else begin
      target = issue_pc + issue_imm;
    end
    link       = issue_pc + XLEN'(4);
    next_pc    = taken ? target : link;
    mispredict = (taken != issue_pred_taken)
               | (taken & (target != issue_pred_target));
    new_e.rob_idx    = issue_rob_idx;
    new_e.taken      = taken;
    new_e.next_pc    = next_pc;
    new_e.link       = link;
    new_e.mispredict = mispredict;
  end

  assign issue_ready = (count_q < FULL);
  assign out_valid   = (count_q != '0);
  assign push        = issue_valid & issue_ready & ~squash;
  assign pop         = out_valid & out_ready & ~squash;
  assign head_e      = mem_q[head_q];

  // head data is masked to zero whenever nothing is valid
  always_comb begin
    out_rob_idx    = '0;
    out_taken      = 1'b0;
    out_next_pc    = '0;
    out_link       = '0;
    out_mispredict = 1'b0;
    if (out_valid) begin
      out_rob_idx    = head_e.rob_idx;
      out_taken      = head_e.taken;
      out_next_pc    = head_e.next_pc;
      out_link       = head_e.link;
      out_mispredict = head_e.mispredict;
    end
  end

  // pointer and occupancy update; squash clears everything
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (squash) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // occupancy and pointer registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // entry storage, written at the tail on accept
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[tail_q] <= new_e;
    end
  end

endmodule
